fifo_reader: RTL

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader_pkg.sv | 16 +
 rtl/fifo_reader_skid.sv | 73 +++++++
 rtl/fifo_reader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the fifo_reader block.
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Occupancy and credit counters hold 0..SKID, SKID is at most 4.
    localparam int CNT_W         = 3;
    localparam int PTR_W         = 2;
    localparam int WORDS_OUT_W   = 32;
    localparam int EMPTY_READS_W = 16;

endpackage

// File: rtl/fifo_reader_skid.sv
// Circular output buffer for fifo_reader: SKID entries, order preserving.
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SKID  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] occupancy
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SKID - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SKID);

    logic [WIDTH-1:0] mem_r [4];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] occ_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
    endfunction

    // Qualify push/pop and present the head word (zero while empty).
    always_comb begin
        pop_ok_s  = pop && (occ_r != {CNT_W{1'b0}});
        push_ok_s = push && ((occ_r != FULL_CNT) || pop_ok_s);
        out_valid = (occ_r != {CNT_W{1'b0}});
        occupancy = occ_r;
        if (out_valid) begin
            out_data = mem_r[rd_ptr_r];
        end else begin
            out_data = {WIDTH{1'b0}};
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   occ_r <= occ_r + CNT_W'(1);
                2'b01:   occ_r <= occ_r - CNT_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Storage has no reset; out_data is masked whenever the ring is empty.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// Credit-based FIFO drain into a skid buffer. Optional FIFO_READER_STATS_EN
// adds saturating words_out / empty_reads counters.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SKID  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic             rd_en,
    input  logic [WIDTH-1:0] rd_data,
    input  logic             rd_valid,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [WORDS_OUT_W-1:0]   words_out,
    output logic [EMPTY_READS_W-1:0] empty_reads
`endif
);

    localparam logic [CNT_W-1:0] SKID_CNT = CNT_W'(SKID);

    state_t           state_r;
    state_t           state_nxt_s;
    logic             inflight_r;
    logic             pop_s;
    logic             push_s;
    logic [CNT_W-1:0] occ_s;
    logic [CNT_W-1:0] credits_s;

    fifo_reader_skid #(
        .WIDTH (WIDTH),
        .SKID  (SKID)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .push_data (rd_data),
        .pop       (pop_s),
        .out_valid (out_valid),
        .out_data  (out_data),
        .occupancy (occ_s)
    );

    // Handshakes and credits; a pop this cycle returns its slot immediately.
    always_comb begin
        pop_s     = out_valid && out_ready;
        push_s    = rd_valid && inflight_r;
        credits_s = SKID_CNT - occ_s - {{(CNT_W-1){1'b0}}, inflight_r}
                    + {{(CNT_W-1){1'b0}}, pop_s};
        busy      = (occ_s != {CNT_W{1'b0}}) || inflight_r;
    end

    // Next state and read request.
    always_comb begin
        state_nxt_s = state_r;
        rd_en       = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: begin
                rd_en = (credits_s != {CNT_W{1'b0}});
                if (!enable) begin
                    state_nxt_s = IDLE;
                end else if (credits_s == {CNT_W{1'b0}}) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            HOLD: begin
                if (!enable) begin
                    state_nxt_s = IDLE;
                end else if (credits_s != {CNT_W{1'b0}}) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and in-flight tracking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            inflight_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            inflight_r <= rd_en;
        end
    end

`ifdef FIFO_READER_STATS_EN
    logic [WORDS_OUT_W-1:0]   words_out_r;
    logic [EMPTY_READS_W-1:0] empty_reads_r;
    logic                     empty_read_s;

    assign empty_read_s = inflight_r && !rd_valid;
    assign words_out    = words_out_r;
    assign empty_reads  = empty_reads_r;

    // Saturating statistics counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            words_out_r   <= {WORDS_OUT_W{1'b0}};
            empty_reads_r <= {EMPTY_READS_W{1'b0}};
        end else begin
            if (pop_s && (words_out_r != {WORDS_OUT_W{1'b1}})) begin
                words_out_r <= words_out_r + WORDS_OUT_W'(1);
            end
            if (empty_read_s && (empty_reads_r != {EMPTY_READS_W{1'b1}})) begin
                empty_reads_r <= empty_reads_r + EMPTY_READS_W'(1);
            end
        end
    end
`endif

endmodule
